// File: rtl/sn74154_sel_arbiter.sv
// Round-robin arbiter sharing one SN74154 4-to-16 decoder among 16 requesters.
// Break-before-make: the address settles with the decoder disabled before each grant.
module sn74154_sel_arbiter #(
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [3:0]  sel,
    output logic        dec_en_n,
    output logic [15:0] grant,
    output logic        busy
);

    localparam int unsigned HOLD_W = 8;
    localparam int unsigned GAP_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACTIVE = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [3:0]          last;
    logic [3:0]          winner;
    logic [3:0]          idx;

    // Nearest requester above last wins; scanning far-to-near lets the nearest overwrite.
    always_comb begin
        winner = last;
        idx    = 4'h0;
        for (int i = 16; i >= 1; i--) begin
            idx = last + 4'(i);
            if (req[idx]) begin
                winner = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= 4'h0;
            dec_en_n <= 1'b1;
            grant    <= 16'h0000;
            busy     <= 1'b0;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            last     <= 4'hF;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 16'h0000) begin
                        sel   <= winner;
                        state <= SETUP;
                        busy  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (req[sel]) begin
                        state    <= ACTIVE;
                        dec_en_n <= 1'b0;
                        grant    <= 16'(1) << sel;
                        hold_cnt <= HOLD_W'(1);
                    end else begin
                        // Requester withdrew before the decoder was ever enabled.
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (!req[sel] || hold_cnt == HOLD_W'(MAX_HOLD)) begin
                        dec_en_n <= 1'b1;
                        grant    <= 16'h0000;
                        last     <= sel;
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_W'(1);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt < GAP_W'(GAP_CYCLES)) begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sn74154_sel_arbiter.sv
// Directed bench for sn74154_sel_arbiter: two parameterisations, hand-computed expectations,
// plus a per-cycle monitor on sel stability and grant/sel agreement.
module tb_sn74154_sel_arbiter;

    logic        clk;
    logic        reset;
    logic [15:0] req_a, req_b;
    logic [3:0]  sel_a, sel_b;
    logic        en_a, en_b;
    logic [15:0] grant_a, grant_b;
    logic        busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    bit mon_on = 1'b0;

    sn74154_sel_arbiter #(.MAX_HOLD(16), .GAP_CYCLES(2)) u_a (
        .clk(clk), .reset(reset), .req(req_a),
        .sel(sel_a), .dec_en_n(en_a), .grant(grant_a), .busy(busy_a)
    );

    sn74154_sel_arbiter #(.MAX_HOLD(4), .GAP_CYCLES(0)) u_b (
        .clk(clk), .reset(reset), .req(req_b),
        .sel(sel_b), .dec_en_n(en_b), .grant(grant_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Length of the current run of dec_en_n at level lvl, current cycle included.
    task automatic run_len(input bit which, input logic lvl, output int n);
        n = 1;
        tick(1);
        while (((which ? en_b : en_a) == lvl) && n < 200) begin
            n++;
            tick(1);
        end
    endtask

    // Invariant monitor; the edge that applies reset is exempt from the sel-stability rule.
    logic [3:0] prev_sel_a, prev_sel_b;
    logic       prev_en_a, prev_en_b, prev_rst;
    always @(negedge clk) begin
        if (mon_on) begin
            check_eq("grant_decode_a", 32'(grant_a), en_a ? 32'h0 : 32'(16'(1) << sel_a));
            check_eq("grant_decode_b", 32'(grant_b), en_b ? 32'h0 : 32'(16'(1) << sel_b));
            if (!prev_rst && (!en_a || !prev_en_a))
                check_eq("sel_stable_a", 32'(sel_a), 32'(prev_sel_a));
            if (!prev_rst && (!en_b || !prev_en_b))
                check_eq("sel_stable_b", 32'(sel_b), 32'(prev_sel_b));
        end
        prev_sel_a = sel_a;
        prev_sel_b = sel_b;
        prev_en_a  = en_a;
        prev_en_b  = en_b;
        prev_rst   = reset;
    end

    int n;
    int order [5] = '{0, 12, 15, 0, 12};

    initial begin
        reset = 1'b1;
        req_a = 16'h0;
        req_b = 16'h0;
        tick(2);
        reset  = 1'b0;
        mon_on = 1'b1;
        check_eq("rst_en_n", 32'(en_a), 32'h1);
        check_eq("rst_grant", 32'(grant_a), 32'h0);
        check_eq("rst_busy", 32'(busy_a), 32'h0);
        check_eq("rst_sel", 32'(sel_a), 32'h0);

        // Single requester 3 held: 16-cycle slot, 4 disabled cycles, re-grant.
        req_a = 16'h0008;
        tick(1);
        check_eq("s1_setup_sel", 32'(sel_a), 32'h3);
        check_eq("s1_setup_en_n", 32'(en_a), 32'h1);
        check_eq("s1_setup_busy", 32'(busy_a), 32'h1);
        tick(1);
        check_eq("s1_latency_en_n", 32'(en_a), 32'h0);
        check_eq("s1_grant", 32'(grant_a), 32'h0008);
        run_len(1'b0, 1'b0, n);
        check_eq("s1_hold_len", 32'(n), 32'd16);
        check_eq("s1_gap_busy", 32'(busy_a), 32'h1);
        run_len(1'b0, 1'b1, n);
        check_eq("s1_turnaround", 32'(n), 32'd4);
        check_eq("s1_regrant", 32'(grant_a), 32'h0008);

        // Early release of requester 5 after 3 low cycles.
        req_a = 16'h0;
        tick(5);
        check_eq("s3_idle_busy", 32'(busy_a), 32'h0);
        req_a = 16'h0020;
        tick(2);
        check_eq("s3_grant", 32'(grant_a), 32'h0020);
        tick(2);
        check_eq("s3_still_low", 32'(en_a), 32'h0);
        req_a = 16'h0;
        tick(1);
        check_eq("s3_release_en_n", 32'(en_a), 32'h1);
        check_eq("s3_release_grant", 32'(grant_a), 32'h0);
        check_eq("s3_gap_busy", 32'(busy_a), 32'h1);
        tick(3);
        check_eq("s3_idle", 32'(busy_a), 32'h0);
        check_eq("s3_grant_after", 32'(grant_a), 32'h0);

        // One-cycle pulse on req[7] aborts in SETUP without touching last.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        req_a = 16'h0080;
        tick(1);
        req_a = 16'h0;
        check_eq("s4_setup_sel", 32'(sel_a), 32'h7);
        check_eq("s4_setup_en_n", 32'(en_a), 32'h1);
        tick(1);
        check_eq("s4_abort_en_n", 32'(en_a), 32'h1);
        check_eq("s4_abort_grant", 32'(grant_a), 32'h0);
        check_eq("s4_abort_busy", 32'(busy_a), 32'h0);
        req_a = 16'h0081;
        tick(2);
        check_eq("s4_first_grant", 32'(grant_a), 32'h0001);
        run_len(1'b0, 1'b0, n);
        check_eq("s4_hold_len", 32'(n), 32'd16);
        run_len(1'b0, 1'b1, n);
        check_eq("s4_second_grant", 32'(grant_a), 32'h0080);
        check_eq("s4_second_sel", 32'(sel_a), 32'h7);

        // Reset while requester 9 is active.
        reset = 1'b1;
        req_a = 16'h0;
        tick(1);
        reset = 1'b0;
        req_a = 16'h0200;
        tick(2);
        check_eq("s5_grant9", 32'(grant_a), 32'h0200);
        tick(2);
        reset = 1'b1;
        req_a = 16'h0201;
        tick(1);
        reset = 1'b0;
        check_eq("s5_rst_en_n", 32'(en_a), 32'h1);
        check_eq("s5_rst_grant", 32'(grant_a), 32'h0);
        check_eq("s5_rst_busy", 32'(busy_a), 32'h0);
        check_eq("s5_rst_sel", 32'(sel_a), 32'h0);
        tick(2);
        check_eq("s5_first_after_rst", 32'(grant_a), 32'h0001);
        req_a = 16'h0;

        // Rotation among 0, 12, 15 with MAX_HOLD=4, GAP_CYCLES=0.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        req_b = 16'h9001;
        tick(2);
        for (int k = 0; k < 5; k++) begin
            check_eq("s2_order", 32'(grant_b), 32'(16'(1) << order[k]));
            run_len(1'b1, 1'b0, n);
            check_eq("s2_hold_len", 32'(n), 32'd4);
            run_len(1'b1, 1'b1, n);
            check_eq("s2_gap_len", 32'(n), 32'd2);
        end
        req_b = 16'h0;
        tick(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sn74154_sel_arbiter.md
Name: sn74154_sel_arbiter

Overview:
Sequential round-robin arbiter that shares one SN74154 4-to-16 decoder among 16 requesters. It drives the decoder address inputs (D,C,B,A on P20..P23) and the enable inputs (G1/G2 on P18/P19). Break-before-make sequencing ensures that no decoder output glitches low while the address changes. It sits between bus-master request logic and the board-level decoder that produces 16 active-low chip selects.

Parameters:
MAX_HOLD, 16, maximum cycles one grant may keep the decoder enabled; legal range 1..255 (8-bit counter).
GAP_CYCLES, 2, dead cycles with the decoder disabled after each grant; legal range 0..15.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  synchronous, active-high reset.
req  input  16  request vector; req[i] high = requester i wants chip select i; held until released.
sel  output  4  decoder address {D,C,B,A}; wire to P20,P21,P22,P23.
dec_en_n  output  1  active-low decoder enable; wire to both P18 (G1) and P19 (G2).
grant  output  16  one-hot grant mirror; grant[i]=1 iff dec_en_n=0 and sel=i.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high on reset. It is sampled only at the rising edge of clk.
- Reset values: state=IDLE, sel=4'h0, dec_en_n=1, grant=16'h0000, busy=0, hold_cnt=0, gap_cnt=0, last=4'hF (requester 0 has first priority).
- The FSM has four states: IDLE, SETUP, ACTIVE, GAP. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set bit searching upward from (last+1) mod 16, wrapping 15 to 0.
  - Load sel=winner and go to SETUP. dec_en_n stays 1.
- SETUP lasts one cycle, with the address settling while the decoder is disabled.
  - If req[sel]=1, go to ACTIVE: dec_en_n=0, grant[sel]=1, hold_cnt=1.
  - If req[sel]=0 (requester withdrew), abort to IDLE. last is not updated and dec_en_n is never asserted.
- ACTIVE, evaluated at each edge:
  - If req[sel]=0 or hold_cnt==MAX_HOLD, release: dec_en_n=1, grant=0, last=sel. Go to GAP with gap_cnt=1 if GAP_CYCLES>0, else go to IDLE.
  - Otherwise hold_cnt increments.
  - With req held, dec_en_n is low for exactly MAX_HOLD cycles.
- GAP: stay while gap_cnt<GAP_CYCLES, incrementing gap_cnt each cycle. Then go to IDLE. dec_en_n=1 for exactly GAP_CYCLES cycles.
- Latency: from req first sampled high in IDLE to dec_en_n low is 2 edges. The minimum slot-to-slot turnaround with continuous requests is GAP_CYCLES+2 cycles with dec_en_n high.
- Invariants:
  - sel never changes while dec_en_n=0, nor during the same cycle dec_en_n rises; it changes only on the IDLE-to-SETUP edge.
  - grant is one-hot or zero and always agrees with sel and dec_en_n.
  - sel retains its last value in IDLE and GAP.
- Requests arriving mid-grant are not pre-empted. They are arbitrated at the next IDLE.
- A requester that re-asserts immediately after release gets the lowest priority relative to other pending requests, because last has been updated.
- Simultaneous reset and any state: reset wins. At the next edge dec_en_n=1, grant=0, last=4'hF.
- X/Z on req is out of scope. Only the listed parameter ranges are supported.

Test Plan:
- Reset then req=16'h0008 held for 40 cycles with MAX_HOLD=16, GAP_CYCLES=2. Required: sel=3; dec_en_n low 2 edges after the first req sample; grant=16'h0008 for exactly 16 cycles; 2 gap cycles; then re-grant of 3.
- req=16'h9001 held continuously, MAX_HOLD=4, GAP_CYCLES=0. Required: grant order 0,12,15,0,12, each for 4 cycles, with dec_en_n high for 2 cycles between grants.
- req=16'h0020 asserted, then dropped after dec_en_n has been low for 3 cycles. Required: release at the edge where req is sampled low, dec_en_n low for 3 cycles total, grant=0 thereafter.
- req[7] pulsed for exactly 1 cycle in IDLE. Required: SETUP aborts, dec_en_n stays 1, grant stays 0, and a later req=16'h0081 grants 0 before 7.
- Assert reset during ACTIVE (sel=9). Required: at the next edge dec_en_n=1, grant=0, busy=0, sel=0. With req[9] and req[0] held, 0 wins first.
- Assertion check across all scenarios: sel is stable whenever dec_en_n=0 or dec_en_n transitions; grant equals the one-hot decode of sel when dec_en_n=0, else 0.
